// File: rtl/matriz_barrido_pkg.sv
// Shared definitions for the LED matrix row scanner: state encodings,
// blank-drive constants and tick-counter sizing.
package matriz_barrido_pkg;

    localparam int unsigned TICK_W    = 16;
    localparam int unsigned ROW_CNT_W = 3;
    localparam int unsigned NUM_ROWS  = 8;

    localparam logic [7:0] ROW_OFF = 8'h00;
    localparam logic [7:0] COL_OFF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHOW  = 2'b10,
        BLANK = 2'b11
    } state_t;

    // Counter preload for a phase of 'ticks' cycles; the last cycle is count 0.
    function automatic logic [TICK_W-1:0] tick_load(input int unsigned ticks);
        return (ticks == 0) ? '0 : TICK_W'(ticks - 1);
    endfunction

endpackage

// File: rtl/matriz_barrido_contador.sv
// Down-counter timing the SHOW and BLANK phases: load, decrement, zero flag.
module matriz_barrido_contador
    import matriz_barrido_pkg::*;
#(
    parameter int unsigned W = TICK_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/matriz_barrido.sv
// Row-multiplexed LED matrix driver: latches a frame from the painter stage,
// then lights each row in turn with an optional all-off gap between rows.
module matriz_barrido
    import matriz_barrido_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS = 8,
    parameter int unsigned ROW_TICKS     = 6250,
    parameter int unsigned BLANK_TICKS   = 250
) (
    input  logic                     BARRIDO_CLOCK_50,
    input  logic                     BARRIDO_RESET_InHigh,
    input  logic                     BARRIDO_ENABLE_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_R7_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_R6_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_R5_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_R4_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_R3_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_R2_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_R1_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_R0_IN,
    output logic [DATAWIDTH_BUS-1:0] BARRIDO_ROW_OUT,
    output logic [DATAWIDTH_BUS-1:0] BARRIDO_COL_OUT,
    output logic                     BARRIDO_FRAME_DONE_OUT
);

    localparam logic [TICK_W-1:0]        ROW_LOAD   = tick_load(ROW_TICKS);
    localparam logic [TICK_W-1:0]        BLANK_LOAD = tick_load(BLANK_TICKS);
    localparam logic [DATAWIDTH_BUS-1:0] ROW_IDLE   = DATAWIDTH_BUS'(ROW_OFF);
    localparam logic [DATAWIDTH_BUS-1:0] COL_IDLE   = DATAWIDTH_BUS'(COL_OFF);
    localparam logic [ROW_CNT_W-1:0]     LAST_ROW   = ROW_CNT_W'(NUM_ROWS - 1);

    logic [DATAWIDTH_BUS-1:0] frame_in [NUM_ROWS];
    logic [DATAWIDTH_BUS-1:0] shadow   [NUM_ROWS];

    state_t                   state;
    state_t                   next_state;
    logic [ROW_CNT_W-1:0]     row;
    logic [ROW_CNT_W-1:0]     next_row;
    logic                     advance;
    logic                     cnt_load;
    logic [TICK_W-1:0]        cnt_value;
    logic                     cnt_dec;
    logic                     tick_zero;
    logic [DATAWIDTH_BUS-1:0] next_row_out;
    logic [DATAWIDTH_BUS-1:0] next_col_out;
    logic                     next_frame_done;

    assign frame_in[0] = BARRIDO_R0_IN;
    assign frame_in[1] = BARRIDO_R1_IN;
    assign frame_in[2] = BARRIDO_R2_IN;
    assign frame_in[3] = BARRIDO_R3_IN;
    assign frame_in[4] = BARRIDO_R4_IN;
    assign frame_in[5] = BARRIDO_R5_IN;
    assign frame_in[6] = BARRIDO_R6_IN;
    assign frame_in[7] = BARRIDO_R7_IN;

    matriz_barrido_contador #(
        .W (TICK_W)
    ) u_contador (
        .clk        (BARRIDO_CLOCK_50),
        .rst        (BARRIDO_RESET_InHigh),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero_c     (tick_zero)
    );

    // Next state, counter control and the output values for the next state.
    always_comb begin
        next_state      = state;
        next_row        = row;
        advance         = 1'b0;
        cnt_load        = 1'b0;
        cnt_value       = '0;
        cnt_dec         = 1'b0;
        next_row_out    = ROW_IDLE;
        next_col_out    = COL_IDLE;
        next_frame_done = 1'b0;

        if (!BARRIDO_ENABLE_IN) begin
            next_state = IDLE;
            next_row   = '0;
            cnt_load   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    next_state = LOAD;
                    next_row   = '0;
                end
                LOAD: begin
                    next_state = SHOW;
                    next_row   = '0;
                    cnt_load   = 1'b1;
                    cnt_value  = ROW_LOAD;
                end
                SHOW: begin
                    if (!tick_zero) begin
                        cnt_dec = 1'b1;
                    end else if (BLANK_TICKS != 0) begin
                        next_state = BLANK;
                        cnt_load   = 1'b1;
                        cnt_value  = BLANK_LOAD;
                    end else begin
                        advance = 1'b1;
                    end
                end
                BLANK: begin
                    if (!tick_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end

        if (advance) begin
            cnt_load = 1'b1;
            if (row != LAST_ROW) begin
                next_row   = row + ROW_CNT_W'(1);
                next_state = SHOW;
                cnt_value  = ROW_LOAD;
            end else begin
                next_row        = '0;
                next_state      = LOAD;
                next_frame_done = 1'b1;
            end
        end

        // Leaving LOAD the shadow is still being written, so take row 0 straight from the inputs.
        if (next_state == SHOW) begin
            next_row_out = DATAWIDTH_BUS'(1) << next_row;
            next_col_out = ~((state == LOAD) ? frame_in[next_row] : shadow[next_row]);
        end
    end

    always_ff @(posedge BARRIDO_CLOCK_50) begin
        if (BARRIDO_RESET_InHigh) begin
            state                  <= IDLE;
            row                    <= '0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                shadow[i] <= '0;
            end
            BARRIDO_ROW_OUT        <= ROW_IDLE;
            BARRIDO_COL_OUT        <= COL_IDLE;
            BARRIDO_FRAME_DONE_OUT <= 1'b0;
        end else begin
            state <= next_state;
            row   <= next_row;
            if (state == LOAD) begin
                shadow <= frame_in;
            end
            BARRIDO_ROW_OUT        <= next_row_out;
            BARRIDO_COL_OUT        <= next_col_out;
            BARRIDO_FRAME_DONE_OUT <= next_frame_done;
        end
    end

endmodule

// File: tb/tb_matriz_barrido.sv
// Scoreboard bench for matriz_barrido: one instance with a blank gap, one without,
// sharing stimulus; a frame-position model predicts every output cycle.
module tb_matriz_barrido;

    localparam int RT = 4;
    localparam int BT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] r [8];
    logic [7:0] row_a, col_a, row_b, col_b;
    logic       fd_a, fd_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [16:0] q_a [$];
    logic [16:0] q_b [$];
    logic [16:0] e_a, e_b;

    bit         m_run [2];
    int         m_pos [2];
    logic [7:0] m_sh  [2][8];

    always #5 clk = ~clk;

    matriz_barrido #(.DATAWIDTH_BUS(8), .ROW_TICKS(RT), .BLANK_TICKS(BT)) dut_a (
        .BARRIDO_CLOCK_50(clk), .BARRIDO_RESET_InHigh(rst), .BARRIDO_ENABLE_IN(en),
        .BARRIDO_R7_IN(r[7]), .BARRIDO_R6_IN(r[6]), .BARRIDO_R5_IN(r[5]), .BARRIDO_R4_IN(r[4]),
        .BARRIDO_R3_IN(r[3]), .BARRIDO_R2_IN(r[2]), .BARRIDO_R1_IN(r[1]), .BARRIDO_R0_IN(r[0]),
        .BARRIDO_ROW_OUT(row_a), .BARRIDO_COL_OUT(col_a), .BARRIDO_FRAME_DONE_OUT(fd_a)
    );

    matriz_barrido #(.DATAWIDTH_BUS(8), .ROW_TICKS(RT), .BLANK_TICKS(0)) dut_b (
        .BARRIDO_CLOCK_50(clk), .BARRIDO_RESET_InHigh(rst), .BARRIDO_ENABLE_IN(en),
        .BARRIDO_R7_IN(r[7]), .BARRIDO_R6_IN(r[6]), .BARRIDO_R5_IN(r[5]), .BARRIDO_R4_IN(r[4]),
        .BARRIDO_R3_IN(r[3]), .BARRIDO_R2_IN(r[2]), .BARRIDO_R1_IN(r[1]), .BARRIDO_R0_IN(r[0]),
        .BARRIDO_ROW_OUT(row_b), .BARRIDO_COL_OUT(col_b), .BARRIDO_FRAME_DONE_OUT(fd_b)
    );

    // Expected {row, col, frame_done} after the coming edge, from position within the frame.
    function automatic logic [16:0] predict(input int i, input int bt);
        logic [7:0] ro;
        logic [7:0] co;
        logic       f;
        int         per;
        int         q;
        ro  = 8'h00;
        co  = 8'hFF;
        f   = 1'b0;
        per = 8 * (RT + bt);
        if (rst || !en) begin
            m_run[i] = 1'b0;
            m_pos[i] = 0;
        end else if (!m_run[i]) begin
            m_run[i] = 1'b1;
            m_pos[i] = 0;
        end else begin
            if (m_pos[i] == 0) begin
                for (int k = 0; k < 8; k++) m_sh[i][k] = r[k];
            end
            m_pos[i] = m_pos[i] + 1;
            if (m_pos[i] > per) begin
                m_pos[i] = 0;
                f = 1'b1;
            end else begin
                q = m_pos[i] - 1;
                if ((q % (RT + bt)) < RT) begin
                    ro = 8'h01 << (q / (RT + bt));
                    co = ~m_sh[i][q / (RT + bt)];
                end
            end
        end
        return {ro, co, f};
    endfunction

    task step();
        q_a.push_back(predict(0, BT));
        q_b.push_back(predict(1, 0));
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic wait_row_a(input logic [7:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (row_a == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fd(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (((which == 0) ? fd_a : fd_b) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Scoreboard: pop one prediction per instance each cycle, plus a one-hot row check.
    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            e_a = q_a.pop_front();
            checks++;
            if ({row_a, col_a, fd_a} !== e_a) begin
                errors++;
                $display("FAIL sb_a cyc %0d: got row=%h col=%h fd=%b, want row=%h col=%h fd=%b",
                         cyc, row_a, col_a, fd_a, e_a[16:9], e_a[8:1], e_a[0]);
            end
            checks++;
            if ($countones(row_a) > 1) begin
                errors++;
                $display("FAIL onehot_a cyc %0d: got row=%h, want at most one bit", cyc, row_a);
            end
        end
        if (q_b.size() > 0) begin
            e_b = q_b.pop_front();
            checks++;
            if ({row_b, col_b, fd_b} !== e_b) begin
                errors++;
                $display("FAIL sb_b cyc %0d: got row=%h col=%h fd=%b, want row=%h col=%h fd=%b",
                         cyc, row_b, col_b, fd_b, e_b[16:9], e_b[8:1], e_b[0]);
            end
            checks++;
            if ($countones(row_b) > 1) begin
                errors++;
                $display("FAIL onehot_b cyc %0d: got row=%h, want at most one bit", cyc, row_b);
            end
        end
    end

    task test_reset();
        rst = 1'b1;
        en  = 1'b0;
        for (int k = 0; k < 8; k++) r[k] = 8'h00;
        step();
        step();
        checks++;
        if (row_a !== 8'h00 || col_a !== 8'hFF || fd_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got row=%h col=%h fd=%b, want 00 FF 0", row_a, col_a, fd_a);
        end
        en = 1'b1;
        step();
        checks++;
        if (row_a !== 8'h00 || col_a !== 8'hFF) begin
            errors++;
            $display("FAIL reset_priority: got row=%h col=%h, want 00 FF", row_a, col_a);
        end
    endtask

    task test_first_frame();
        r[0] = 8'hA5;
        rst  = 1'b0;
        step();
        checks++;
        if (row_a !== 8'h00 || col_a !== 8'hFF || fd_a !== 1'b0 || fd_b !== 1'b0) begin
            errors++;
            $display("FAIL first_load: got row=%h col=%h fd=%b/%b, want 00 FF 0/0", row_a, col_a, fd_a, fd_b);
        end
        for (int c = 2; c <= 5; c++) begin
            step();
            checks++;
            if (row_a !== 8'h01 || col_a !== 8'h5A) begin
                errors++;
                $display("FAIL row0_show c%0d: got row=%h col=%h, want 01 5A", c, row_a, col_a);
            end
        end
        for (int c = 6; c <= 7; c++) begin
            step();
            checks++;
            if (row_a !== 8'h00 || col_a !== 8'hFF) begin
                errors++;
                $display("FAIL row0_blank c%0d: got row=%h col=%h, want 00 FF", c, row_a, col_a);
            end
        end
    endtask

    task test_free_run();
        bit         ok;
        int         pulses;
        int         first_at;
        int         second_at;
        int         rows_seen [8];
        logic [7:0] sel;
        for (int k = 0; k < 8; k++) r[k] = 8'(17 * (k + 1));
        wait_fd(0, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL free_run_sync: got no frame_done in 60 cycles, want one");
        end
        pulses = 0; first_at = 0; second_at = 0;
        for (int k = 0; k < 8; k++) rows_seen[k] = 0;
        for (int i = 1; i <= 98; i++) begin
            step();
            if (fd_a) begin
                pulses++;
                if (pulses == 1) first_at = i;
                if (pulses == 2) second_at = i;
            end
            for (int k = 0; k < 8; k++) begin
                sel = 8'h01 << k;
                if (row_a == sel) rows_seen[k]++;
            end
        end
        checks++;
        if (pulses != 2 || first_at != 49 || second_at != 98) begin
            errors++;
            $display("FAIL frame_period: got %0d pulses at %0d,%0d, want 2 at 49,98", pulses, first_at, second_at);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rows_seen[k] != 8) begin
                errors++;
                $display("FAIL row_time r%0d: got %0d cycles, want 8", k, rows_seen[k]);
            end
        end
    endtask

    task test_tear_free();
        bit ok;
        r[3] = 8'h0F;
        wait_fd(0, 60, ok);
        wait_row_a(8'h02, 20, ok);
        r[3] = 8'hF0;
        wait_row_a(8'h08, 20, ok);
        checks++;
        if (!ok || col_a !== 8'hF0) begin
            errors++;
            $display("FAIL tear_same_frame: got ok=%0d col=%h, want 1 F0", ok, col_a);
        end
        wait_row_a(8'h02, 60, ok);
        wait_row_a(8'h08, 20, ok);
        checks++;
        if (!ok || col_a !== 8'h0F) begin
            errors++;
            $display("FAIL tear_next_frame: got ok=%0d col=%h, want 1 0F", ok, col_a);
        end
    endtask

    task test_enable_drop();
        bit ok;
        wait_row_a(8'h20, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_sync: got no row 5 in 60 cycles, want row 5");
        end
        en = 1'b0;
        step();
        checks++;
        if (row_a !== 8'h00 || col_a !== 8'hFF || fd_a !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got row=%h col=%h fd=%b, want 00 FF 0", row_a, col_a, fd_a);
        end
        for (int i = 0; i < 3; i++) step();
        en = 1'b1;
        step();
        checks++;
        if (row_a !== 8'h00 || col_a !== 8'hFF || fd_a !== 1'b0) begin
            errors++;
            $display("FAIL reenable_load: got row=%h col=%h fd=%b, want 00 FF 0", row_a, col_a, fd_a);
        end
        step();
        checks++;
        if (row_a !== 8'h01 || col_a !== 8'hEE) begin
            errors++;
            $display("FAIL reenable_row0: got row=%h col=%h, want 01 EE", row_a, col_a);
        end
    endtask

    task test_reset_blank();
        bit ok;
        wait_row_a(8'h04, 60, ok);
        wait_row_a(8'h00, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_blank_sync: got no row-2 blank, want one");
        end
        rst = 1'b1;
        step();
        checks++;
        if (row_a !== 8'h00 || col_a !== 8'hFF || fd_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_blank_off: got row=%h col=%h fd=%b, want 00 FF 0", row_a, col_a, fd_a);
        end
        rst = 1'b0;
        step();
        checks++;
        if (row_a !== 8'h00 || fd_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_blank_load: got row=%h fd=%b, want 00 0", row_a, fd_a);
        end
        step();
        checks++;
        if (row_a !== 8'h01) begin
            errors++;
            $display("FAIL rst_blank_row0: got row=%h, want 01", row_a);
        end
    endtask

    task test_no_blank();
        bit ok;
        int zeros;
        wait_fd(1, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL noblank_sync: got no frame_done in 40 cycles, want one");
        end
        zeros = 0;
        for (int i = 1; i <= 33; i++) begin
            step();
            if (i < 33 && row_b == 8'h00) zeros++;
            if (i == 32) begin
                checks++;
                if (row_b !== 8'h80) begin
                    errors++;
                    $display("FAIL noblank_row7: got row=%h, want 80", row_b);
                end
            end
            if (i == 33) begin
                checks++;
                if (fd_b !== 1'b1) begin
                    errors++;
                    $display("FAIL noblank_period: got fd=%b at cycle 33, want 1", fd_b);
                end
            end
        end
        checks++;
        if (zeros != 0) begin
            errors++;
            $display("FAIL noblank_gaps: got %0d all-off cycles, want 0", zeros);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_free_run();
        test_tear_free();
        test_enable_drop();
        test_reset_blank();
        test_no_blank();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end by time 100000, want finish");
        $fatal(1);
    end

endmodule

// File: doc/matriz_barrido.md
MATRIZ_BARRIDO -- requirements
Module: MATRIZ_BARRIDO

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 8, SHALL set the row width, the column width and the number of rows.
REQ-002 Parameter ROW_TICKS, default 6250, SHALL set the clock cycles each row is lit; legal range 1..65535.
REQ-003 Parameter BLANK_TICKS, default 250, SHALL set the all-off clock cycles after each row; legal range 0..65535.
REQ-004 Port BARRIDO_CLOCK_50 SHALL be an input, 1 bit: the single system clock; all logic on the rising edge.
REQ-005 Port BARRIDO_RESET_InHigh SHALL be an input, 1 bit: the reset, synchronous and active-high.
REQ-006 Port BARRIDO_ENABLE_IN SHALL be an input, 1 bit: 1 = scan the matrix, 0 = matrix dark.
REQ-007 Ports BARRIDO_R7_IN .. BARRIDO_R0_IN SHALL be inputs, 8 bits each: row images from the painter stage; bit i = column i lit.
REQ-008 Port BARRIDO_ROW_OUT SHALL be an output, 8 bits: one-hot, active-high row select; bit k drives row k.
REQ-009 Port BARRIDO_COL_OUT SHALL be an output, 8 bits: active-low column drive.
REQ-010 Port BARRIDO_FRAME_DONE_OUT SHALL be an output, 1 bit: a one-cycle pulse per completed frame.

Function
REQ-011 The FSM SHALL have the states IDLE, LOAD, SHOW and BLANK, plus a 3-bit row counter and a 16-bit tick counter.
REQ-012 IDLE: if ENABLE=1, the next state SHALL be LOAD; otherwise the FSM SHALL stay in IDLE; row counter held at 0.
REQ-013 LOAD, which lasts 1 cycle, SHALL copy all eight R*_IN into a shadow frame register; the next state SHALL be SHOW with row 0.
REQ-014 SHOW SHALL last exactly ROW_TICKS cycles; ROW_OUT = 1<<row; COL_OUT = ~shadow[row]; the next state SHALL be BLANK, or go directly to the row advance if BLANK_TICKS=0.
REQ-015 BLANK SHALL last exactly BLANK_TICKS cycles with ROW_OUT=8'h00 and COL_OUT=8'hFF.
REQ-016 Row advance: if row<7, the row counter SHALL increment and the next state SHALL be SHOW; if row=7, the row counter SHALL wrap to 0 and the next state SHALL be LOAD.
REQ-017 FRAME_DONE SHALL be 1 during a LOAD entered from the row-7 advance, and 0 during the first LOAD after IDLE and in all other cycles.
REQ-018 R*_IN changes outside LOAD SHALL NOT affect the outputs until the next LOAD; this guarantees tear-free frames.
REQ-019 All outputs SHALL be registered and SHALL correspond to the current state; ROW_OUT SHALL never have more than one bit set.
REQ-020 In IDLE and in LOAD, ROW_OUT SHALL be 8'h00 and COL_OUT SHALL be 8'hFF.
REQ-021 If ENABLE=0 in any state, the FSM SHALL go to IDLE on the next cycle, abandoning the partial frame with no FRAME_DONE; the tick and row counters SHALL clear.
REQ-022 The frame period SHALL be 1 + 8*(ROW_TICKS+BLANK_TICKS) cycles.

Reset
REQ-023 With RESET=1 at a clock edge, the FSM SHALL go to IDLE and the row and tick counters and the shadow register SHALL clear.
REQ-024 On that same edge, ROW_OUT SHALL become 8'h00, COL_OUT 8'hFF and FRAME_DONE 0.
REQ-025 Reset SHALL take priority over ENABLE; a reset mid-SHOW SHALL blank the matrix on the next edge.

Structure
REQ-026 The state encodings (IDLE=2'b00, LOAD=2'b01, SHOW=2'b10, BLANK=2'b11) and the blank constants (ROW_OFF=8'h00, COL_OFF=8'hFF) SHALL live in the shared game package.
REQ-027 The tick counter SHALL be the sub-module MATRIZ_BARRIDO_CONTADOR: load value, decrement, zero flag.
REQ-028 The block SHALL sit directly downstream of the painter stage, consuming its eight row buses unchanged.

Verification (ROW_TICKS=4, BLANK_TICKS=2)
REQ-029 Reset, then ENABLE=1 with R0_IN=8'hA5 -> LOAD at cycle 1; ROW_OUT=8'h01 and COL_OUT=8'h5A for cycles 2..5; all-off for cycles 6..7.
REQ-030 Free-run two frames with distinct rows -> each row k shown 4 cycles as 1<<k; FRAME_DONE pulses once per 49 cycles; the first LOAD has FRAME_DONE=0.
REQ-031 R3_IN changed from 8'h0F to 8'hF0 during the row-1 SHOW -> row 3 still shows COL_OUT=8'hF0 in this frame, 8'h0F in the next.
REQ-032 ENABLE dropped during the row-5 SHOW -> next cycle IDLE with outputs off and no FRAME_DONE; re-enable restarts at LOAD then row 0.
REQ-033 RESET pulsed during the row-2 BLANK -> next cycle ROW_OUT=8'h00, COL_OUT=8'hFF, state IDLE; with ENABLE held, LOAD follows.
REQ-034 Rerun with BLANK_TICKS=0 -> rows are back-to-back with no all-off cycles; frame = 33 cycles; one-hot assertion holds every cycle.
